// File: rtl/vmem_pkg.sv
// vmem_pkg: shared state and command types for the vector memory stream unit
package vmem_pkg;
  localparam int VMEM_AW = 12;
  localparam int VMEM_LW = 8;
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} vmem_state_t;
  typedef struct packed {
    logic               store;
    logic [VMEM_AW-1:0] base;
    logic [VMEM_AW-1:0] stride;
    logic [VMEM_LW-1:0] len;
  } vmem_cmd_t;
endpackage

// File: rtl/vmem_ret_fifo.sv
// vmem_ret_fifo: load-return buffer with occupancy count and simultaneous push/pop
module vmem_ret_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          push,
  input  logic [W-1:0]  pushData,
  input  logic          pop,
  output logic [W-1:0]  popData,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  assign popData = mem[rdPtr];
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= pushData;
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= push ? wrPtr + AW'(1) : wrPtr;
      rdPtr <= pop ? rdPtr + AW'(1) : rdPtr;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/vector_mem_stream_unit.sv
// vector_mem_stream_unit: turns strided vector load/store commands into per-element memory traffic
module vector_mem_stream_unit
  import vmem_pkg::*;
#(
  parameter int memDepth = VMEM_AW,
  parameter int LEN_W = VMEM_LW,
  parameter int BUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_store,
  input  logic [memDepth-1:0] cmd_base,
  input  logic [memDepth-1:0] cmd_stride,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [31:0]         st_data,
  output logic                ld_valid,
  input  logic                ld_ready,
  output logic [31:0]         ld_data,
  output logic                ld_last,
  output logic                done,
  output logic [memDepth-1:0] mem_InAddress,
  output logic [31:0]         mem_DataIn,
  output logic                mem_WE,
  output logic [memDepth-1:0] mem_OutAddress,
  input  logic [31:0]         mem_DataOut
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  vmem_state_t state;
  vmem_cmd_t cmdIn;
  logic [memDepth-1:0] addr, stride, outAddr;
  logic [LEN_W-1:0] len, issued, popped;
  logic [CW-1:0] occ;
  logic [31:0] head;
  logic inflight, issue, pop, wr;
  assign cmdIn = '{store: cmd_store, base: cmd_base, stride: cmd_stride, len: cmd_len};
  assign cmd_ready = state == IDLE;
  assign done = state == DONE;
  assign st_ready = state == STORE && issued < len;
  assign wr = st_valid && st_ready;
  assign mem_WE = wr;
  assign mem_InAddress = wr ? addr : '0;
  assign mem_DataIn = wr ? st_data : '0;
  // Occupancy is taken before this cycle's pop so a read can never overrun the buffer.
  assign issue = state == LOAD && issued < len && (32'(occ) + 32'(inflight)) < BUF_DEPTH;
  assign mem_OutAddress = issue ? addr : outAddr;
  assign ld_valid = state == LOAD && occ != '0;
  assign ld_data = ld_valid ? head : '0;
  assign ld_last = ld_valid && popped == len - LEN_W'(1);
  assign pop = ld_valid && ld_ready;
  vmem_ret_fifo #(.DEPTH(BUF_DEPTH), .W(32), .CW(CW)) retFifo (
    .clk(clk),
    .RESET(RESET),
    .push(inflight),
    .pushData(mem_DataOut),
    .pop(pop),
    .popData(head),
    .count(occ)
  );
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      addr <= '0;
      stride <= '0;
      outAddr <= '0;
      len <= '0;
      issued <= '0;
      popped <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) outAddr <= addr;
      if (wr || issue) begin
        addr <= addr + stride;
        issued <= issued + LEN_W'(1);
      end
      if (pop) popped <= popped + LEN_W'(1);
      case (state)
        IDLE:
          if (cmd_valid) begin
            addr <= cmdIn.base;
            stride <= cmdIn.stride;
            len <= cmdIn.len;
            issued <= '0;
            popped <= '0;
            state <= cmdIn.len == '0 ? DONE : cmdIn.store ? STORE : LOAD;
          end
        STORE: if (wr && issued == len - LEN_W'(1)) state <= DONE;
        LOAD:  if (pop && popped == len - LEN_W'(1)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vector_mem_stream_unit.sv
// tb_vector_mem_stream_unit: directed command table plus reset-abort sequence against a memory model
module tb_vector_mem_stream_unit;
  logic clk = 0, RESET = 0;
  logic cmd_valid = 0, cmd_ready, cmd_store = 0;
  logic [11:0] cmd_base = 0, cmd_stride = 0;
  logic [7:0] cmd_len = 0;
  logic st_valid = 0, st_ready;
  logic [31:0] st_data = 0;
  logic ld_valid, ld_ready = 0, ld_last, done, mem_WE;
  logic [31:0] ld_data, mem_DataIn, mem_DataOut;
  logic [11:0] mem_InAddress, mem_OutAddress;
  logic [31:0] mem [4096];
  logic [31:0] refMem [4096];
  int nVec = 0, nErr = 0;

  vector_mem_stream_unit dut (
    .clk(clk), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .done(done),
    .mem_InAddress(mem_InAddress), .mem_DataIn(mem_DataIn), .mem_WE(mem_WE),
    .mem_OutAddress(mem_OutAddress), .mem_DataOut(mem_DataOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_WE) mem[mem_InAddress] <= mem_DataIn;
    mem_DataOut <= mem[mem_OutAddress];
  end

  typedef struct {
    logic store;
    logic [11:0] base;
    logic [11:0] stride;
    logic [7:0] len;
    int pct;
    logic gap;
    int expFirst;
    int expDone;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic runCmd(input vec_t v);
    int k = 0, first = -1, doneAt = -1, lastAct = -1;
    logic [11:0] prevOut, ea;
    @(negedge clk);
    cmd_valid = 1; cmd_store = v.store; cmd_base = v.base; cmd_stride = v.stride; cmd_len = v.len;
    #1;
    check("cmd_ready_at_accept", cmd_ready, 1);
    prevOut = mem_OutAddress;
    for (int cyc = 1; cyc < 300 && doneAt < 0; cyc++) begin
      @(negedge clk);
      cmd_valid = 0;
      ld_ready = $urandom_range(99) < v.pct;
      st_valid = v.store && (!v.gap || cyc % 3 == 1);
      st_data = 32'(k + 1) * 32'h11;
      #1;
      ea = v.base + 12'(k) * v.stride;
      check("st_ready", st_ready, v.store && k < int'(v.len));
      check("mem_WE", mem_WE, v.store && st_valid && k < int'(v.len));
      if (v.len == 0) check("len0_no_read", mem_OutAddress, prevOut);
      if (mem_WE) begin
        check("wr_addr", mem_InAddress, ea);
        check("wr_data", mem_DataIn, st_data);
        refMem[ea] = st_data;
        if (first < 0) first = cyc;
        lastAct = cyc;
        k++;
      end
      if (ld_valid && ld_ready) begin
        check("ld_data", ld_data, refMem[ea]);
        check("ld_last", ld_last, k == int'(v.len) - 1);
        if (first < 0) first = cyc;
        lastAct = cyc;
        k++;
      end
      if (done) doneAt = cyc;
    end
    st_valid = 0;
    ld_ready = 0;
    check("done_seen", doneAt >= 0, 1);
    check("element_count", k, 32'(v.len));
    if (v.expFirst > 0) check("first_element_cycle", first, v.expFirst);
    if (v.expDone > 0) check("done_cycle", doneAt, v.expDone);
    if (v.len != 0) check("done_after_last", doneAt, lastAct + 1);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("cmd_ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    vec_t v;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'hA000_0000 + 32'(i);
      refMem[i] = 32'hA000_0000 + 32'(i);
    end
    tbl[0] = '{store: 0, base: 12'h010, stride: 12'd1, len: 8'd4, pct: 100, gap: 0, expFirst: 3, expDone: 7};
    tbl[1] = '{store: 1, base: 12'hFFE, stride: 12'd1, len: 8'd4, pct: 0, gap: 0, expFirst: 1, expDone: 5};
    tbl[2] = '{store: 0, base: 12'h000, stride: 12'd3, len: 8'd8, pct: 30, gap: 0, expFirst: 0, expDone: 0};
    tbl[3] = '{store: 1, base: 12'h040, stride: 12'd5, len: 8'd0, pct: 0, gap: 0, expFirst: 0, expDone: 1};
    tbl[4] = '{store: 1, base: 12'h200, stride: 12'h010, len: 8'd4, pct: 0, gap: 1, expFirst: 1, expDone: 11};
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_done", done, 0);
    check("rst_mem_WE", mem_WE, 0);
    check("rst_out_addr", mem_OutAddress, 0);
    @(negedge clk);
    RESET = 1;
    for (int i = 0; i < 5; i++) runCmd(tbl[i]);

    @(negedge clk);
    cmd_valid = 1; cmd_store = 0; cmd_base = 12'h100; cmd_stride = 12'd1; cmd_len = 8'd6;
    pops = 0;
    for (int c = 0; c < 20 && pops < 2; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      ld_ready = 1;
      #1;
      if (ld_valid && ld_ready) begin
        check("abort_ld_data", ld_data, refMem[12'h100 + 12'(pops)]);
        pops++;
      end
    end
    check("abort_pops", pops, 2);
    @(negedge clk);
    RESET = 0;
    #1;
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_ld_valid", ld_valid, 0);
    check("abort_ld_data_zero", ld_data, 0);
    check("abort_ld_last", ld_last, 0);
    check("abort_st_ready", st_ready, 0);
    check("abort_mem_WE", mem_WE, 0);
    check("abort_out_addr", mem_OutAddress, 0);
    check("abort_in_addr", mem_InAddress, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", done, 0);
    end
    @(negedge clk);
    RESET = 1;
    ld_ready = 0;
    #1;
    check("release_cmd_ready", cmd_ready, 1);
    check("release_ld_valid", ld_valid, 0);
    v = '{store: 0, base: 12'h100, stride: 12'd1, len: 8'd6, pct: 100, gap: 0, expFirst: 3, expDone: 9};
    runCmd(v);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
